// File: rtl/dram_fifo_arb_pkg.sv
// Shared types and helpers for the two-requester DRAM-backed FIFO.
package dram_fifo_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } out_state_e;

  typedef logic req_idx_t;

  // Advance a circular pointer, wrapping from depth-1 back to 0 (depth need not be a power of two).
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/dram_fifo_arb_dist_ram_dp.sv
// Distributed dual-port RAM: synchronous write, registered read port with clock-enable and sync reset.
// Latency: read data appears one edge after qdpo_ce; no backpressure, the caller gates qdpo_ce.
module dist_ram_dp #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 34,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  input  logic             qdpo_ce,
  input  logic             qdpo_rst,
  output logic [WIDTH-1:0] qdpo
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (qdpo_rst)     qdpo <= '0;
    else if (qdpo_ce) qdpo <= mem[ra];
  end

endmodule

// File: rtl/dram_fifo_arb.sv
// Two-requester round-robin write arbiter feeding a DEPTH-entry RAM FIFO plus output register (optional DRAM_FIFO_ARB_ALMOST_FULL_EN).
// Latency: 2 cycles from accepted write to out_valid; backpressure: both readies drop when full or in reset.
module dram_fifo_arb
  import dram_fifo_arb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 34,
  parameter int AW    = 6
`ifdef DRAM_FIFO_ARB_ALMOST_FULL_EN
  , parameter int AF_THRESH = DEPTH - 4
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
`ifdef DRAM_FIFO_ARB_ALMOST_FULL_EN
  , output logic           almost_full
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  req_idx_t         rr_ptr;
  out_state_e       state;
  logic [AW:0]      count_nxt;
  logic             wr;
  logic             issue;
  logic             pop;
  logic [WIDTH-1:0] wr_data;

  assign full      = (count == DEPTH_C);
  assign out_valid = (state == VALID);
  assign empty     = (count == '0) & ~out_valid;

  // Single-valid wins outright; contention goes to the side the pointer names.
  assign req0_ready = reset_n & ~full & req0_valid & (~req1_valid | (rr_ptr == 1'b0));
  assign req1_ready = reset_n & ~full & req1_valid & (~req0_valid | (rr_ptr == 1'b1));

  assign wr      = req0_ready | req1_ready;
  assign wr_data = req1_ready ? req1_data : req0_data;
  assign pop     = out_valid & out_ready;
  // count reflects the previous edge, so a same-cycle write is never read back here.
  assign issue   = (count != '0) & (~out_valid | out_ready);

  always_comb begin
    count_nxt = count;
    if (wr & ~issue)      count_nxt = count + 1'b1;
    else if (~wr & issue) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      rr_ptr <= 1'b0;
      state  <= EMPTY;
    end else begin
      if (wr) begin
        wp     <= AW'(ptr_wrap(32'(wp), DEPTH));
        rr_ptr <= ~req1_ready;
      end
      if (issue) rp <= AW'(ptr_wrap(32'(rp), DEPTH));
      count <= count_nxt;
      case (state)
        EMPTY:   if (issue) state <= VALID;
        VALID:   if (pop & ~issue) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

  dist_ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .we       (wr),
    .wa       (wp),
    .wd       (wr_data),
    .ra       (rp),
    .qdpo_ce  (issue),
    .qdpo_rst (~reset_n),
    .qdpo     (out_data)
  );

`ifdef DRAM_FIFO_ARB_ALMOST_FULL_EN
  localparam logic [AW:0] AF_C = (AW+1)'(AF_THRESH);

  always_ff @(posedge clk) begin
    if (!reset_n) almost_full <= 1'b0;
    else          almost_full <= (count_nxt >= AF_C);
  end
`endif

endmodule

// File: doc/dram_fifo_arb.md
DRAM_FIFO_ARB -- requirements
Module: dram_fifo_arb

Interface
REQ-001 Parameter: WIDTH, default 64, data bits per entry.
REQ-002 Parameter: DEPTH, default 34, RAM entries; any value 2..64, not required to be a power of two.
REQ-003 Parameter: AW, default 6, address bits; 2**AW >= DEPTH.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 req0_valid / req1_valid  input  1 each  requester write request.
REQ-007 req0_data / req1_data  input  WIDTH each  requester write data.
REQ-008 req0_ready / req1_ready  output  1 each  grant; a transfer occurs when valid & ready are both high in the same cycle.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  WIDTH  head entry, driven directly from the registered RAM read port.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
REQ-012 count  output  AW+1  entries held in the RAM, excluding the output register; range 0..DEPTH.
REQ-013 full / empty  output  1 each  full = (count==DEPTH); empty = (count==0) & !out_valid.

Function
REQ-014 Arbiter: round-robin between two requesters, at most one write per cycle, and no grant while full.
- req0_ready / req1_ready are combinational from valid, priority pointer and full.
- Only one requester valid: that requester is granted.
- Both valid: the pointer side is granted.
- After each transfer, the pointer moves to the non-granted side.
REQ-015 The write pointer wp writes the granted data to ram[wp] and then increments; it wraps from DEPTH-1 to 0.
REQ-016 Read issue condition: (count>0) & (!out_valid | out_ready). On issue:
- rp is presented to the read port with qdpo_ce=1;
- rp increments, wrapping from DEPTH-1 to 0;
- out_valid is set on the next edge.
REQ-017 When out_valid & out_ready and no read is issued in that cycle, out_valid clears and out_data holds its previous value.
REQ-018 Output FSM states:
- EMPTY -> VALID on read issue.
- VALID -> VALID on (pop & issue) or on !pop.
- VALID -> EMPTY on (pop & !issue).
REQ-019 Latency from accepted write (cycle N) to out_valid is 2 cycles, i.e. out_valid is high in cycle N+2 when the FIFO was empty.
REQ-020 Simultaneous write and read issue in one cycle leaves count unchanged.
REQ-021 A read never targets an entry written in the same cycle, because issue requires count>0 from the prior state.
REQ-022 Total storage is DEPTH+1 entries: DEPTH in RAM plus the output register.
REQ-023 Entries are delivered in acceptance order; entries from the same requester are never reordered.

Reset
REQ-024 While reset_n=0 at a rising edge, the following clear: wp=0, rp=0, count=0, out_valid=0, out_data=0, and the pointer selects req0.
REQ-025 RAM contents are not cleared by reset.
REQ-026 Both readies are 0 during reset cycles.
REQ-027 Reset asserted mid-stream discards all stored entries.

Configuration
REQ-028 Macro DRAM_FIFO_ARB_ALMOST_FULL_EN.
- Defined: adds parameter AF_THRESH (default DEPTH-4) and output almost_full (1 bit, registered), high when count >= AF_THRESH after the current edge. almost_full resets to 0.
- Undefined: neither the port nor the parameter exists, and there is no related logic.

Structure
REQ-029 The shared package holds:
- the output FSM state enum (EMPTY, VALID);
- the requester index typedef (1 bit);
- a pointer-wrap helper function taking ptr and DEPTH.
REQ-030 One sub-module, dist_ram_dp: distributed dual-port RAM with a synchronous write port and a read port with registered output, clock-enable and synchronous reset. It is instantiated once.

Verification
REQ-031 Reset, then req0 writes 0xA5 in cycle 1 -> out_valid=1 in cycle 3 with out_data=0xA5; count goes 1 then 0.
REQ-032 Both requesters continuously valid, out_ready=1 -> grants alternate 0,1,0,1; the first grant goes to req0 after reset.
REQ-033 out_ready=0, req0 writes 35 entries (DEPTH=34) -> count=34, full=1, out_valid=1, ready=0; the 36th write is held off. With out_ready=1, a new grant occurs within 2 cycles.
REQ-034 Push and pop 100 sequential values with random valid/ready -> output is in order with no loss or duplication; wp and rp wrap past 33 to 0 at least twice.
REQ-035 Reset asserted with count=10 and out_valid=1 -> next cycle count=0, out_valid=0, empty=1; a subsequent write delivers the new data only.
REQ-036 With the macro defined and AF_THRESH=30 -> almost_full rises on the edge at which count reaches 30 and falls when count drops to 29.
